loop_ctrl_deadtime_drv: RTL and testbench
=========================================

Name: loop_ctrl_deadtime_drv

Overview:
Digital gate-drive sequencer for the LOOP/CONTROL power stage. It turns a single PWM request into complementary high-side/low-side enables, which feed the 5V inverter drive bricks. It enforces programmable dead time, minimum on-time and a sticky fault shutdown, and it guarantees that both sides are never enabled together.

Parameters:
DT_WIDTH, 6, width of dt_cfg and of the dead-time counter
MIN_ON, 4, minimum cycles a side stays on before it can be released (1..255)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
CELV  input  1  brick supply pin; no logic function
CELG  input  1  brick ground pin; no logic function
SUB  input  1  substrate pin; no logic function
en  input  1  driver enable; 0 forces both sides off
pwm_i  input  1  PWM request, synchronous to clk; 1 = high side, 0 = low side
dt_cfg  input  DT_WIDTH  dead time in cycles; sampled on entry to a dead-time state
fault_i  input  1  external fault, level-sensitive
fault_clr  input  1  fault release request, one-cycle pulse or level
hs_o  output  1  high-side enable, to inverter brick input
ls_o  output  1  low-side enable, to inverter brick input
busy_o  output  1  1 while in a dead-time state
fault_o  output  1  1 while latched in FAULT

Behaviour:
- State register is one-hot. States: OFF, DT_TO_LS, LS_ON, DT_TO_HS, HS_ON, FAULT.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - hs_o = (state==HS_ON)
  - ls_o = (state==LS_ON)
  - busy_o = DT_TO_LS or DT_TO_HS
  - fault_o = (state==FAULT)
- Reset (rst=1 at an edge, from any state, including mid dead time or mid on-time): state OFF, all outputs 0, both counters 0. This takes priority over every other input.
- Priority each edge: rst > fault_i > en=0 > normal transitions.
- fault_i=1 in any non-FAULT state: go to FAULT and clear hs_o and ls_o on that edge. No dead time is applied, because both sides turn off.
- FAULT: stays there until an edge with fault_clr=1 and fault_i=0, then goes to OFF. fault_clr while fault_i=1 is ignored and does not linger.
- en=0 in any state other than FAULT: go to OFF on that edge, both outputs 0.
- OFF with en=1: go to DT_TO_LS and load the dead-time counter. Start-up always passes through a dead time to the low side, regardless of pwm_i.
- Dead-time counter:
  - On entry to DT_TO_x, load dtc = max(dt_cfg,1). dt_cfg=0 is treated as 1, so there is at least 1 cycle with both sides off.
  - Decrement each cycle. When the count expires, enter the target ON state.
  - Resulting timing: both outputs are 0 for exactly max(dt_cfg,1) cycles.
  - A dt_cfg change during a dead time does not affect that dead time.
- On-time counter: cleared on entry to LS_ON/HS_ON and incremented each cycle, saturating at MIN_ON.
- LS_ON to DT_TO_HS: when pwm_i=1 and the on-time count is at least MIN_ON (the entry cycle counts as cycle 1). HS_ON to DT_TO_LS: the same rule with pwm_i=0.
- A pwm_i change before MIN_ON is reached is not latched. It is acted on only if still present once MIN_ON is satisfied.
- pwm_i toggling during a dead time has no effect; the dead time always completes to its target.
- Edge latency: pwm_i rises at edge k with min-on satisfied.
  - Edge k: ls_o=0, busy_o=1.
  - Edge k+max(dt_cfg,1): hs_o=1, busy_o=0.
- Invariant: hs_o & ls_o == 0 on every cycle. Any transition between the two sides has at least 1 cycle of both off.

Test Plan:
- Reset then en=1, pwm_i=0, dt_cfg=5: outputs 0 for 5 cycles with busy_o=1, then ls_o=1.
- In LS_ON past MIN_ON, raise pwm_i with dt_cfg=3: ls_o drops at that edge; hs_o=1 exactly 3 edges later; hs_o&ls_o never 1.
- dt_cfg=0: every side change shows exactly 1 cycle with both outputs 0.
- MIN_ON=4: enter HS_ON and pulse pwm_i low for 2 cycles starting cycle 1 -> hs_o remains 1. Hold pwm_i low instead -> leave HS_ON at the 4th-cycle edge.
- fault_i=1 mid DT_TO_HS -> FAULT next edge, fault_o=1. fault_clr=1 with fault_i=1 -> stays FAULT. fault_i=0 then fault_clr=1 -> OFF, then restart through DT_TO_LS.
- rst asserted while hs_o=1 and en held 1: all outputs 0 next edge. Deassert rst -> DT_TO_LS sequence restarts. en=0 mid dead time -> OFF.

Source files
------------

// File: rtl/loop_ctrl_deadtime_drv.sv
// loop_ctrl_deadtime_drv
// Gate-drive sequencer for the LOOP/CONTROL power stage. A single PWM request
// is turned into complementary high-side / low-side enables for the 5V
// inverter drive bricks. It applies a programmable dead time between sides,
// a minimum on-time per side, and a sticky fault shutdown. hs_o and ls_o are
// never high together.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   CELV/CELG/SUB  brick supply / ground / substrate pins, no logic function
//   en         driver enable, 0 forces both sides off
//   pwm_i      PWM request, 1 = high side, 0 = low side
//   dt_cfg     dead time in cycles, sampled on entry to a dead-time state
//   fault_i    external fault, level-sensitive
//   fault_clr  fault release request
//   hs_o/ls_o  high-side / low-side enables
//   busy_o     1 while in a dead-time state
//   fault_o    1 while latched in FAULT
module loop_ctrl_deadtime_drv #(
  parameter int DT_WIDTH = 6,
  parameter int MIN_ON   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CELV,
  input  logic                CELG,
  input  logic                SUB,
  input  logic                en,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] dt_cfg,
  input  logic                fault_i,
  input  logic                fault_clr,
  output logic                hs_o,
  output logic                ls_o,
  output logic                busy_o,
  output logic                fault_o
);

  // One-hot state encoding
  localparam logic [5:0] S_OFF      = 6'b000001;
  localparam logic [5:0] S_DT_TO_LS = 6'b000010;
  localparam logic [5:0] S_LS_ON    = 6'b000100;
  localparam logic [5:0] S_DT_TO_HS = 6'b001000;
  localparam logic [5:0] S_HS_ON    = 6'b010000;
  localparam logic [5:0] S_FAULT    = 6'b100000;

  // MIN_ON is at most 255, so 8 bits always hold the saturated count.
  localparam int ONC_W = 8;
  localparam logic [ONC_W-1:0]    ONC_ONE   = {{(ONC_W-1){1'b0}}, 1'b1};
  localparam logic [ONC_W-1:0]    ONC_SAT   = ONC_W'(MIN_ON);
  // The count is cleared on entry and the entry cycle is cycle 1, so the
  // release condition at an edge is "count already reached MIN_ON-1".
  localparam logic [ONC_W-1:0]    ONC_REL   = ONC_W'(MIN_ON - 1);
  localparam logic [DT_WIDTH-1:0] DT_ONE    = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  logic [5:0]          state_reg, state_next;
  logic [DT_WIDTH-1:0] dtc_reg, dtc_next;
  logic [ONC_W-1:0]    onc_reg, onc_next;
  logic [DT_WIDTH-1:0] dt_load;
  logic [ONC_W-1:0]    onc_inc;
  logic                hs_reg, ls_reg, busy_reg, fault_reg;

  // Supply/substrate pins exist only for netlist connectivity.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  // A zero dead time still yields one cycle with both sides off.
  assign dt_load = (dt_cfg == '0) ? DT_ONE : dt_cfg;
  assign onc_inc = (onc_reg < ONC_SAT) ? (onc_reg + ONC_ONE) : onc_reg;

  always_comb begin
    state_next = state_reg;
    dtc_next   = dtc_reg;
    onc_next   = onc_reg;
    if (fault_i) begin
      // Both sides drop at once, so no dead time is needed.
      state_next = S_FAULT;
    end else if (state_reg == S_FAULT) begin
      if (fault_clr) begin
        state_next = S_OFF;
      end
    end else if (!en) begin
      state_next = S_OFF;
    end else begin
      case (state_reg)
        S_OFF: begin
          // Start-up always goes through a dead time to the low side.
          state_next = S_DT_TO_LS;
          dtc_next   = dt_load;
        end
        S_DT_TO_LS: begin
          if (dtc_reg <= DT_ONE) begin
            state_next = S_LS_ON;
            onc_next   = '0;
          end else begin
            dtc_next = dtc_reg - DT_ONE;
          end
        end
        S_DT_TO_HS: begin
          if (dtc_reg <= DT_ONE) begin
            state_next = S_HS_ON;
            onc_next   = '0;
          end else begin
            dtc_next = dtc_reg - DT_ONE;
          end
        end
        S_LS_ON: begin
          onc_next = onc_inc;
          if (pwm_i && (onc_reg >= ONC_REL)) begin
            state_next = S_DT_TO_HS;
            dtc_next   = dt_load;
          end
        end
        S_HS_ON: begin
          onc_next = onc_inc;
          if (!pwm_i && (onc_reg >= ONC_REL)) begin
            state_next = S_DT_TO_LS;
            dtc_next   = dt_load;
          end
        end
        default: begin
          // Corrupted one-hot value: recover to a safe state.
          state_next = S_OFF;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_OFF;
      dtc_reg   <= '0;
      onc_reg   <= '0;
      hs_reg    <= 1'b0;
      ls_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dtc_reg   <= dtc_next;
      onc_reg   <= onc_next;
      hs_reg    <= (state_next == S_HS_ON);
      ls_reg    <= (state_next == S_LS_ON);
      busy_reg  <= (state_next == S_DT_TO_LS) || (state_next == S_DT_TO_HS);
      fault_reg <= (state_next == S_FAULT);
    end
  end

  assign hs_o    = hs_reg;
  assign ls_o    = ls_reg;
  assign busy_o  = busy_reg;
  assign fault_o = fault_reg;

endmodule

// File: tb/tb_loop_ctrl_deadtime_drv.sv
// Testbench for loop_ctrl_deadtime_drv: directed stimulus pushes the expected
// {hs_o, ls_o, busy_o, fault_o} for each edge into a queue; a monitor pops
// and compares after every edge and also checks hs_o & ls_o == 0.
module tb_loop_ctrl_deadtime_drv;
  localparam int DT_WIDTH = 6;
  localparam int MIN_ON   = 4;

  // Expected output patterns {hs, ls, busy, fault}
  localparam logic [3:0] X_OFF = 4'b0000;
  localparam logic [3:0] X_DT  = 4'b0010;
  localparam logic [3:0] X_LS  = 4'b0100;
  localparam logic [3:0] X_HS  = 4'b1000;
  localparam logic [3:0] X_FLT = 4'b0001;

  logic clk = 1'b0;
  logic rst, celv, celg, sub, en, pwm_i, fault_i, fault_clr;
  logic [DT_WIDTH-1:0] dt_cfg;
  logic hs_o, ls_o, busy_o, fault_o;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  loop_ctrl_deadtime_drv #(.DT_WIDTH(DT_WIDTH), .MIN_ON(MIN_ON)) dut (
    .clk(clk), .rst(rst), .CELV(celv), .CELG(celg), .SUB(sub),
    .en(en), .pwm_i(pwm_i), .dt_cfg(dt_cfg),
    .fault_i(fault_i), .fault_clr(fault_clr),
    .hs_o(hs_o), .ls_o(ls_o), .busy_o(busy_o), .fault_o(fault_o)
  );

  // Inputs are already set by the caller; push the expectation for the
  // coming edge, then move just past that edge.
  task automatic step(input logic [3:0] exp, input string name);
    exp_t e;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one line per transaction.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] act;
    act = {hs_o, ls_o, busy_o, fault_o};
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: hs/ls/busy/fault=%b expected %b at %0t", e.name, act, e.exp, $time);
      end else begin
        $display("ok   %s: hs/ls/busy/fault=%b", e.name, act);
      end
    end
    if (rst === 1'b0) begin
      checks++;
      if ((hs_o & ls_o) !== 1'b0) begin
        errors++;
        $display("FAIL overlap: hs_o=%b ls_o=%b expected not both 1 at %0t", hs_o, ls_o, $time);
      end
    end
  end

  initial begin
    celv = 1'b1; celg = 1'b0; sub = 1'b0;
    rst = 1'b1; en = 1'b0; pwm_i = 1'b0; dt_cfg = 6'd5;
    fault_i = 1'b0; fault_clr = 1'b0;

    // Reset state
    step(X_OFF, "reset");
    step(X_OFF, "reset_hold");

    // Start-up: 5 cycles of dead time, then low side
    rst = 1'b0; en = 1'b1;
    repeat (5) step(X_DT, "startup_dt5");
    step(X_LS, "startup_ls_on");
    repeat (5) step(X_LS, "ls_hold");

    // LS -> HS with dt=3, pwm toggling during the dead time is ignored
    dt_cfg = 6'd3; pwm_i = 1'b1;
    step(X_DT, "ls_drop_on_pwm_rise");
    pwm_i = 1'b0;
    step(X_DT, "dt3_pwm_toggle");
    pwm_i = 1'b1;
    step(X_DT, "dt3_last");
    step(X_HS, "hs_on_after_dt3");

    // Min-on: 2-cycle low pulse right after entry does not release HS
    pwm_i = 1'b0;
    step(X_HS, "minon_pulse_c1");
    step(X_HS, "minon_pulse_c2");
    pwm_i = 1'b1;
    repeat (3) step(X_HS, "minon_pulse_ignored");

    // dt_cfg=0 gives exactly one both-off cycle
    dt_cfg = 6'd0; pwm_i = 1'b0;
    step(X_DT, "dt0_to_ls");
    step(X_LS, "dt0_ls_on");

    // Held request releases LS at the 4th-cycle edge
    pwm_i = 1'b1;
    repeat (3) step(X_LS, "minon_hold_ls");
    step(X_DT, "minon_release_ls");
    step(X_HS, "dt0_hs_on");

    // Held request releases HS at the 4th-cycle edge
    pwm_i = 1'b0;
    repeat (3) step(X_HS, "minon_hold_hs");
    step(X_DT, "minon_release_hs");
    step(X_LS, "dt0_ls_on2");

    // Fault in the middle of DT_TO_HS
    dt_cfg = 6'd4; pwm_i = 1'b1;
    repeat (3) step(X_LS, "pre_fault_ls");
    step(X_DT, "pre_fault_dt");
    step(X_DT, "pre_fault_dt2");
    fault_i = 1'b1;
    step(X_FLT, "fault_entry");
    fault_clr = 1'b1;
    step(X_FLT, "fault_clr_ignored");
    fault_clr = 1'b0;
    step(X_FLT, "fault_clr_no_linger");
    fault_i = 1'b0;
    step(X_FLT, "fault_sticky");
    fault_clr = 1'b1;
    step(X_OFF, "fault_released");
    fault_clr = 1'b0; pwm_i = 1'b0;

    // Restart with dt=4; a dt_cfg change mid dead time has no effect
    step(X_DT, "restart_dt4");
    dt_cfg = 6'd1;
    repeat (3) step(X_DT, "restart_dt_unchanged");
    step(X_LS, "restart_ls_on");

    // Reach HS, then reset while hs_o=1 with en held
    dt_cfg = 6'd2; pwm_i = 1'b1;
    repeat (3) step(X_LS, "pre_rst_ls");
    step(X_DT, "pre_rst_dt");
    step(X_DT, "pre_rst_dt2");
    step(X_HS, "pre_rst_hs");
    rst = 1'b1;
    step(X_OFF, "rst_from_hs");
    rst = 1'b0;
    step(X_DT, "post_rst_dt");

    // en=0 mid dead time forces OFF
    en = 1'b0;
    step(X_OFF, "en_low_mid_dt");
    en = 1'b1; pwm_i = 1'b0;
    step(X_DT, "en_restart_dt");
    step(X_DT, "en_restart_dt2");
    step(X_LS, "en_restart_ls");
    en = 1'b0;
    step(X_OFF, "en_low_in_ls");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
